// File: rtl/vga_sync_gen_if.sv
// vga_sync_gen_if: raster timing bundle from the sync generator to the
// display pipeline.
//   pix_tick      - one-clk strobe on each pixel advance
//   hsync_sig     - horizontal sync, active-low
//   vsync_sig     - vertical sync, active-low
//   ready_sig     - current pixel is inside the visible area
//   col_addr_sig  - visible column, 0 outside the visible area
//   row_addr_sig  - visible row, 0 outside the visible area
//   frame_start   - one-clk pulse when the position becomes (0,0)
interface vga_sync_gen_if;
  logic        pix_tick;
  logic        hsync_sig;
  logic        vsync_sig;
  logic        ready_sig;
  logic [10:0] col_addr_sig;
  logic [10:0] row_addr_sig;
  logic        frame_start;

  modport master (
    output pix_tick, hsync_sig, vsync_sig, ready_sig,
           col_addr_sig, row_addr_sig, frame_start
  );

  modport slave (
    input  pix_tick, hsync_sig, vsync_sig, ready_sig,
           col_addr_sig, row_addr_sig, frame_start
  );
endinterface

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: VGA raster timing generator.
// Divides clk by CLK_DIV to a pixel rate, runs 11-bit horizontal/vertical
// position counters and decodes sync, visible-area flag and coordinates.
// Ports:
//   clk   - system clock
//   rst_n - asynchronous active-low reset
//   vga   - timing outputs (vga_sync_gen_if.master)
// CLK_DIV must be 1..15; H/V totals must not exceed 2048.
module vga_sync_gen #(
  parameter int CLK_DIV  = 2,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic            clk,
  input  logic            rst_n,
  vga_sync_gen_if.master  vga
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [3:0]  DIV_LAST = 4'(CLK_DIV - 1);
  localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_ACT    = 11'(H_ACTIVE);
  localparam logic [10:0] V_ACT    = 11'(V_ACTIVE);
  localparam logic [10:0] HS_BEG   = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] VS_BEG   = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);

  logic [3:0]  div_cnt;
  logic [10:0] h_cnt, v_cnt;
  logic [10:0] h_nxt, v_nxt;
  logic        tick, h_wrap, act_nxt;

  // With CLK_DIV=1 DIV_LAST is 0, so tick stays high permanently.
  assign tick         = (div_cnt == DIV_LAST);
  assign h_wrap       = (h_cnt == H_LAST);
  assign vga.pix_tick = tick;

  always_comb begin
    h_nxt = h_cnt;
    v_nxt = v_cnt;
    if (tick) begin
      h_nxt = h_wrap ? 11'd0 : h_cnt + 11'd1;
      if (h_wrap)
        v_nxt = (v_cnt == V_LAST) ? 11'd0 : v_cnt + 11'd1;
    end
  end

  assign act_nxt = (h_nxt < H_ACT) && (v_nxt < V_ACT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) div_cnt <= '0;
    else        div_cnt <= tick ? 4'd0 : div_cnt + 4'd1;
  end

  // Counters reset to the last position so the first advance lands on (0,0).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= H_LAST;
      v_cnt <= V_LAST;
    end else begin
      h_cnt <= h_nxt;
      v_cnt <= v_nxt;
    end
  end

  // Outputs decode the next position so they change on the same edge as
  // the counters: no decode glitches and no added latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vga.hsync_sig    <= 1'b1;
      vga.vsync_sig    <= 1'b1;
      vga.ready_sig    <= 1'b0;
      vga.col_addr_sig <= '0;
      vga.row_addr_sig <= '0;
      vga.frame_start  <= 1'b0;
    end else begin
      vga.hsync_sig    <= !((h_nxt >= HS_BEG) && (h_nxt < HS_END));
      vga.vsync_sig    <= !((v_nxt >= VS_BEG) && (v_nxt < VS_END));
      vga.ready_sig    <= act_nxt;
      vga.col_addr_sig <= act_nxt ? h_nxt : 11'd0;
      vga.row_addr_sig <= act_nxt ? v_nxt : 11'd0;
      // Gate with tick: position (0,0) is held for CLK_DIV clks.
      vga.frame_start  <= tick && (h_nxt == 11'd0) && (v_nxt == 11'd0);
    end
  end
endmodule

// File: tb/tb_vga_sync_gen.sv
module tb_vga_sync_gen;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vga_sync_gen_if if_a ();
  vga_sync_gen_if if_b ();
  vga_sync_gen_if if_c ();

  // a: full VGA timing; b/c: shrunk raster so whole frames fit the run.
  vga_sync_gen #(.CLK_DIV(2)) dut_a (.clk(clk), .rst_n(rst_n), .vga(if_a));
  vga_sync_gen #(.CLK_DIV(3), .H_ACTIVE(40), .H_FP(4), .H_SYNC(6), .H_BP(5),
                 .V_ACTIVE(20), .V_FP(2), .V_SYNC(2), .V_BP(3))
    dut_b (.clk(clk), .rst_n(rst_n), .vga(if_b));
  vga_sync_gen #(.CLK_DIV(1), .H_ACTIVE(40), .H_FP(4), .H_SYNC(6), .H_BP(5),
                 .V_ACTIVE(20), .V_FP(2), .V_SYNC(2), .V_BP(3))
    dut_c (.clk(clk), .rst_n(rst_n), .vga(if_c));

  // clk edges seen since reset release
  int k;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) k <= 0;
    else        k <= k + 1;

  int checks = 0;
  int errors = 0;

  logic [26:0] obs_a, obs_b, obs_c;
  assign obs_a = {if_a.pix_tick, if_a.hsync_sig, if_a.vsync_sig, if_a.ready_sig,
                  if_a.col_addr_sig, if_a.row_addr_sig, if_a.frame_start};
  assign obs_b = {if_b.pix_tick, if_b.hsync_sig, if_b.vsync_sig, if_b.ready_sig,
                  if_b.col_addr_sig, if_b.row_addr_sig, if_b.frame_start};
  assign obs_c = {if_c.pix_tick, if_c.hsync_sig, if_c.vsync_sig, if_c.ready_sig,
                  if_c.col_addr_sig, if_c.row_addr_sig, if_c.frame_start};

  // Reference: after kk edges there have been kk/cd pixel advances; the
  // raster position is a linear pixel index starting one before (0,0).
  function automatic logic [26:0] model(int kk, int cd, int ha, int hfp, int hsw,
                                        int hbp, int va, int vfp, int vsw, int vbp);
    int ht, vt, n, lin, h, v;
    logic pix, hs, vs, rdy, fs;
    logic [10:0] col, row;
    ht  = ha + hfp + hsw + hbp;
    vt  = va + vfp + vsw + vbp;
    n   = kk / cd;
    lin = (n + ht * vt - 1) % (ht * vt);
    h   = lin % ht;
    v   = lin / ht;
    pix = ((kk % cd) == cd - 1);
    hs  = !(h >= ha + hfp && h < ha + hfp + hsw);
    vs  = !(v >= va + vfp && v < va + vfp + vsw);
    rdy = (h < ha) && (v < va);
    col = rdy ? 11'(h) : 11'd0;
    row = rdy ? 11'(v) : 11'd0;
    fs  = (kk > 0) && ((kk % cd) == 0) && (lin == 0);
    return {pix, hs, vs, rdy, col, row, fs};
  endfunction

  task automatic check_vec(input string tag, input logic [26:0] o, input logic [26:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s k=%0d observed=%h expected=%h", tag, k, o, e);
    end
  endtask

  task automatic check_int(input string tag, input int o, input int e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
    end
  endtask

  task automatic check_all();
    check_vec("a_raster", obs_a, model(k, 2, 640, 16, 96, 48, 480, 10, 2, 33));
    check_vec("b_raster", obs_b, model(k, 3, 40, 4, 6, 5, 20, 2, 2, 3));
    check_vec("c_raster", obs_c, model(k, 1, 40, 4, 6, 5, 20, 2, 2, 3));
  endtask

  // Checks while running from reset release, with line/frame measurements.
  int   a_fall_k, a_low, a_ready, a_nfall;
  int   b_fs_k, b_ready, b_nfs, b_vlow, b_nvfall;
  int   c_low, c_nrise, c_tick0;
  logic a_hs_prev, b_vs_prev, c_hs_prev;

  initial begin
    // reset held 10 clks
    rst_n = 1'b0;
    repeat (10) begin
      @(negedge clk);
      check_all();
    end
    rst_n = 1'b1;

    a_fall_k = 0; a_low = 0; a_ready = 0; a_nfall = 0; a_hs_prev = 1'b1;
    b_fs_k = 0; b_ready = 0; b_nfs = 0; b_vlow = 0; b_nvfall = 0; b_vs_prev = 1'b1;
    c_low = 0; c_nrise = 0; c_tick0 = 0; c_hs_prev = 1'b1;

    repeat (9000) begin
      @(negedge clk);
      check_all();
      // a: hsync falls at h=656 -> edge 657*2, period 1600, low 192, 1280 ready clks/line
      if (a_hs_prev && !if_a.hsync_sig) begin
        if (a_nfall == 0) check_int("a_first_hfall_k", k, 1314);
        else              check_int("a_hperiod", k - a_fall_k, 1600);
        check_int("a_ready_per_line", a_ready, 1280);
        a_ready = 0; a_fall_k = k; a_nfall++;
      end
      if (!if_a.hsync_sig) a_low++;
      if (!a_hs_prev && if_a.hsync_sig) begin
        check_int("a_hlow", a_low, 192);
        a_low = 0;
      end
      if (if_a.ready_sig) a_ready++;
      a_hs_prev = if_a.hsync_sig;
      // b: frame 55*27*3 clks, 40*20*3 ready clks, vsync low 2*55*3 from row 22 wrap
      if (if_b.frame_start) begin
        if (b_nfs == 0) check_int("b_first_fs_k", k, 3);
        else begin
          check_int("b_frame_period", k - b_fs_k, 4455);
          check_int("b_ready_per_frame", b_ready, 2400);
        end
        b_ready = 0; b_fs_k = k; b_nfs++;
      end
      if (if_b.ready_sig) b_ready++;
      if (b_vs_prev && !if_b.vsync_sig) begin
        check_int("b_vfall_k", k - 4455 * b_nvfall, 3633);
        b_nvfall++;
      end
      if (!if_b.vsync_sig) b_vlow++;
      if (!b_vs_prev && if_b.vsync_sig) begin
        check_int("b_vlow", b_vlow, 330);
        b_vlow = 0;
      end
      b_vs_prev = if_b.vsync_sig;
      // c: CLK_DIV=1, tick never drops, hsync low 6 clks
      if (!if_c.pix_tick) c_tick0++;
      if (!if_c.hsync_sig) c_low++;
      if (!c_hs_prev && if_c.hsync_sig) begin
        check_int("c_hlow", c_low, 6);
        c_low = 0; c_nrise++;
      end
      c_hs_prev = if_c.hsync_sig;
    end
    check_int("a_nfall", a_nfall, 5);
    check_int("b_nfs", b_nfs, 3);
    check_int("b_nvfall", b_nvfall, 2);
    check_int("c_tick_zero", c_tick0, 0);
    check_int("c_nrise_min", int'(c_nrise >= 100), 1);

    // directed mid-frame reset at b position (30,10): edge 3*(10*55+30+1)
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (1743) begin
      @(negedge clk);
      check_all();
    end
    check_int("b_pre_reset_col", int'(if_b.col_addr_sig), 30);
    check_int("b_pre_reset_row", int'(if_b.row_addr_sig), 10);
    #2 rst_n = 1'b0;
    #1 check_all();
    check_int("b_async_ready", int'(if_b.ready_sig), 0);

    // randomized hold lengths and reset points
    for (int r = 0; r < 4; r++) begin
      repeat (int'($urandom_range(5, 1))) begin
        @(negedge clk);
        check_all();
      end
      rst_n = 1'b1;
      repeat (int'($urandom_range(4500, 20))) begin
        @(negedge clk);
        check_all();
      end
      #($urandom_range(4, 1)) rst_n = 1'b0;
      #0.5 check_all();
    end
    @(negedge clk);
    check_all();
    rst_n = 1'b1;
    repeat (50) begin
      @(negedge clk);
      check_all();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
